// File: rtl/sm2_pkg.sv
// sm2_pkg
// Shared definitions for the SM2 modular-multiplication result path:
// the SM2 field prime p, the default word and result widths, and the state
// encoding of the result collector FSM.
// Optional feature macro: MODRES_CANON_EN adds the CANON state, in which the
// collected value is reduced once by p before it is presented.
package sm2_pkg;

  localparam int IO_WIDTH_DEF  = 32;
  localparam int CAL_WIDTH_DEF = 256;

  // SM2 recommended-curve prime p
  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  // Encodings are fixed so that IDLE/COLLECT/HOLD are identical in both builds
`ifdef MODRES_CANON_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CANON   = 2'd2,
    HOLD    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/sm2_cond_sub.sv
// sm2_cond_sub
// Purely combinational single-step reduction by the SM2 prime:
// y = (a >= p) ? a - p : a. One step is enough because the value fed in
// is always below 2p.
// Ports:
//   a : 256-bit input value
//   y : 256-bit reduced value
module sm2_cond_sub
  import sm2_pkg::*;
(
  input  logic [255:0] a,
  output logic [255:0] y
);

  logic [255:0] diff;

  assign diff = a - SM2_P;
  assign y    = (a >= SM2_P) ? diff : a;

endmodule

// File: rtl/mod_mult_res_collect.sv
// mod_mult_res_collect
// Collects WORDS = CAL_WIDTH/IO_WIDTH result words (most-significant word
// first) from a modular multiplier, assembles them into one CAL_WIDTH-bit
// value and holds it for the downstream consumer with a valid/ready handshake.
// Optional feature macro: MODRES_CANON_EN inserts a one-cycle CANON state
// that reduces the assembled value once by the SM2 prime (sm2_cond_sub).
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : upstream word valid
//   in_ready  : block accepts a word this cycle (IDLE and COLLECT)
//   din       : result word, most-significant word first
//   flush     : synchronous abort, discards partial or held result
//   out_valid : res holds a complete result (HOLD)
//   out_ready : downstream takes res
//   res       : assembled result, zero whenever out_valid is low
//   busy      : FSM is not in IDLE
module mod_mult_res_collect
  import sm2_pkg::*;
#(
  parameter int IO_WIDTH  = IO_WIDTH_DEF,
  parameter int CAL_WIDTH = CAL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IO_WIDTH-1:0]  din,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CAL_WIDTH-1:0] res,
  output logic                 busy
);

  localparam int WORDS = CAL_WIDTH / IO_WIDTH;
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [CAL_WIDTH-1:0] acc;
  logic [CAL_WIDTH-1:0] acc_shift;
  logic [CAL_WIDTH-1:0] res_q;
  logic                 accept;
  logic                 last_word;

  assign in_ready  = (state == IDLE) || (state == COLLECT);
  assign busy      = (state != IDLE);
  assign out_valid = (state == HOLD);
  assign res       = res_q;

  assign accept    = in_valid && in_ready;
  assign last_word = accept && (cnt == CNT_W'(WORDS - 1));
  assign acc_shift = {acc[CAL_WIDTH-IO_WIDTH-1:0], din};

`ifdef MODRES_CANON_EN
  logic [CAL_WIDTH-1:0] acc_red;

  sm2_cond_sub u_cond_sub (
    .a (acc),
    .y (acc_red)
  );
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush overrides every other transition
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COLLECT: begin
        if (last_word) begin
`ifdef MODRES_CANON_EN
          state_nxt = CANON;
`else
          state_nxt = HOLD;
`endif
        end else if (accept) begin
          state_nxt = COLLECT;
        end
      end
`ifdef MODRES_CANON_EN
      CANON: state_nxt = HOLD;
`endif
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) begin
      state_nxt = IDLE;
    end
  end

  // Word counter, shift accumulator and held result. res_q is only ever
  // non-zero while in HOLD: it is loaded on the edge entering HOLD and
  // cleared on the edge leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      res_q <= '0;
    end else if (flush) begin
      cnt   <= '0;
      acc   <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        acc <= acc_shift;
        cnt <= last_word ? '0 : cnt + CNT_W'(1);
      end
`ifdef MODRES_CANON_EN
      if (state == CANON) begin
        res_q <= acc_red;
      end
`else
      if (last_word) begin
        res_q <= acc_shift;
      end
`endif
      if ((state == HOLD) && out_ready) begin
        res_q <= '0;
        acc   <= '0;
      end
    end
  end

endmodule

// File: doc/mod_mult_res_collect.md
MOD_MULT_RES_COLLECT -- requirements
Module: mod_mult_res_collect

Interface
REQ-001 The block SHALL have parameter IO_WIDTH, default 32, meaning the width of one input word.
REQ-002 The block SHALL have parameter CAL_WIDTH, default 256, meaning the width of the assembled result; CAL_WIDTH/IO_WIDTH (WORDS, default 8) SHALL be an integer.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the upstream result word is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-007 The block SHALL have port din, input, IO_WIDTH bits, the result word, most-significant word first.
REQ-008 The block SHALL have port flush, input, 1 bit, a synchronous abort that discards any partial or held result.
REQ-009 The block SHALL have port out_valid, output, 1 bit, meaning res holds a complete result.
REQ-010 The block SHALL have port out_ready, input, 1 bit, meaning the downstream consumer takes res.
REQ-011 The block SHALL have port res, output, CAL_WIDTH bits, the assembled modular-multiplication result.
REQ-012 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, COLLECT, CANON (present only with MODRES_CANON_EN) and HOLD.
REQ-014 A word SHALL be accepted on a cycle where in_valid and in_ready are both high; in_ready SHALL be high in IDLE and COLLECT and low in CANON and HOLD.
REQ-015 On each accepted word the shift register SHALL update as {acc[CAL_WIDTH-IO_WIDTH-1:0], din}, and the word counter (0..WORDS-1) SHALL increment.
REQ-016 IDLE SHALL go to COLLECT on the first accepted word; in_valid low in COLLECT SHALL hold all state (no timeout).
REQ-017 On acceptance of word WORDS-1 the counter SHALL wrap to 0 and the FSM SHALL go to CANON if compiled in, else HOLD; the final word SHALL be included in the result.
REQ-018 CANON SHALL last exactly one cycle, then go to HOLD.
REQ-019 In HOLD out_valid SHALL be 1 and res stable until out_ready is sampled high; then IDLE on the next edge with out_valid 0.
REQ-020 Latency SHALL be 1 cycle (no canon) or 2 cycles (canon) from the edge accepting the last word to out_valid high.
REQ-021 res SHALL drive the registered result only; res SHALL be 0 whenever out_valid is 0.
REQ-022 flush high SHALL, on the next edge, force IDLE, clear counter and accumulator, and drop out_valid; flush SHALL take priority over every other event, including a simultaneous word acceptance or out_ready.
REQ-023 A new result SHALL NOT be accepted until the held one is consumed; back-to-back results SHALL have at least one IDLE cycle.

Reset
REQ-024 While rst_n is low: state IDLE, counter 0, accumulator 0, in_ready 1, out_valid 0, res 0, busy 0.
REQ-025 Reset asserted mid-COLLECT or mid-HOLD SHALL discard the partial or held result with no output pulse.

Configuration
REQ-026 Macro MODRES_CANON_EN SHALL, when defined, include CANON: if acc >= SM2 prime p, res = acc - p, else res = acc.
REQ-027 Without MODRES_CANON_EN, CANON and the subtractor SHALL be absent and res SHALL be acc unmodified.

Structure
REQ-028 A shared package sm2_pkg SHALL hold the SM2 prime p (256-bit), CAL_WIDTH/IO_WIDTH defaults and the FSM state enum.
REQ-029 The conditional subtraction SHALL be the sub-module sm2_cond_sub (combinational, 256-bit compare and subtract), instantiated only under MODRES_CANON_EN.

Verification
REQ-030 Eight words 0x00000000..0x00000007 with in_valid held high, out_ready high -> res = 0x00000000_00000001_..._00000007, out_valid 1 cycle (canon off) after the last word, then IDLE.
REQ-031 Canon on, words forming p+5 -> res = 5; words forming p-1 -> res = p-1 unchanged.
REQ-032 in_valid gaps of 3 cycles after words 2 and 6, out_ready held low 10 cycles -> result correct, res stable and in_ready low throughout HOLD.
REQ-033 flush asserted together with word 5 acceptance -> next cycle IDLE, busy 0; a following full 8-word burst produces a result containing no stale words.
REQ-034 rst_n pulsed low during HOLD -> out_valid drops asynchronously, all outputs at reset values; following 8 words of 0xFFFFFFFF -> res = all-ones (canon off) or all-ones minus p (canon on).
